// File: rtl/acc_requant_stream.sv
// Accumulator drain stage: reads accumulator rows, requantizes each lane to int8
// and streams finished rows out through a credit-protected output FIFO.
module acc_requant_stream #(
   parameter int ARRAY_COL  = 16,
   parameter int ACC_WIDTH  = 32,
   parameter int OUT_WIDTH  = 8,
   parameter int ADDR_WIDTH = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [ADDR_WIDTH:0]             cfg_rows,
   input  logic signed [15:0]              cfg_mult,
   input  logic [4:0]                      cfg_shift,
   input  logic signed [7:0]               cfg_zero_point,
   input  logic                            cfg_relu,
   input  logic [ARRAY_COL*ACC_WIDTH-1:0]  bias_vec,
   output logic                            busy,
   output logic                            done,
   output logic                            acc_rd_en,
   output logic [ADDR_WIDTH-1:0]           acc_rd_addr,
   input  logic [ARRAY_COL*ACC_WIDTH-1:0]  acc_rd_data,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [ARRAY_COL*OUT_WIDTH-1:0]  m_data,
   output logic                            m_last
);
   localparam int SUM_W  = ACC_WIDTH + 1;
   localparam int PROD_W = SUM_W + 16;
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int ROW_W  = ARRAY_COL * OUT_WIDTH;

   localparam logic signed [PROD_W:0] RND_ONE = {{PROD_W{1'b0}}, 1'b1};
   localparam logic signed [PROD_W:0] OUT_MAX = {{(PROD_W-OUT_WIDTH+2){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [PROD_W:0] OUT_MIN = {{(PROD_W-OUT_WIDTH+2){1'b1}}, {(OUT_WIDTH-1){1'b0}}};
   localparam logic [ADDR_WIDTH:0]    ONE_ROW = {{ADDR_WIDTH{1'b0}}, 1'b1};
   localparam logic [PTR_W-1:0]       PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};
   localparam logic [PTR_W:0]         CNT_ONE = {{PTR_W{1'b0}}, 1'b1};

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

   function automatic logic signed [PROD_W-1:0] bias_scale(
      input logic signed [ACC_WIDTH-1:0] acc,
      input logic signed [ACC_WIDTH-1:0] bias,
      input logic signed [15:0]          mult
   );
      logic signed [SUM_W-1:0] sum;
      sum = $signed({acc[ACC_WIDTH-1], acc}) + $signed({bias[ACC_WIDTH-1], bias});
      return $signed({{(PROD_W-SUM_W){sum[SUM_W-1]}}, sum}) *
             $signed({{(PROD_W-16){mult[15]}}, mult});
   endfunction

   function automatic logic signed [PROD_W-1:0] round_shift(
      input logic signed [PROD_W-1:0] p,
      input logic [4:0]               sh
   );
      logic signed [PROD_W:0] t;
      t = $signed({p[PROD_W-1], p});
      if (sh != 5'd0)
         t = t + (RND_ONE <<< (sh - 5'd1));
      t = t >>> sh;
      return t[PROD_W-1:0];
   endfunction

   function automatic logic [OUT_WIDTH-1:0] zp_saturate(
      input logic signed [PROD_W-1:0] r,
      input logic signed [7:0]        zp,
      input logic                     relu
   );
      logic signed [PROD_W:0] y;
      logic signed [PROD_W:0] zp_ext;
      logic signed [PROD_W:0] lower;
      zp_ext = $signed({{(PROD_W-7){zp[7]}}, zp});
      y      = $signed({r[PROD_W-1], r}) + zp_ext;
      lower  = relu ? zp_ext : OUT_MIN;
      if (y > OUT_MAX)
         y = OUT_MAX;
      else if (y < lower)
         y = lower;
      return y[OUT_WIDTH-1:0];
   endfunction

   state_t                   state;
   logic [ADDR_WIDTH:0]      rows_q;
   logic [ADDR_WIDTH:0]      issue_cnt;
   logic                     rd_last;
   logic signed [15:0]       mult_q;
   logic [4:0]               shift_q;
   logic signed [7:0]        zp_q;
   logic                     relu_q;

   logic                     vld_p0, vld_p1, vld_p2, vld_p3;
   logic                     last_p0, last_p1, last_p2, last_p3;
   logic signed [PROD_W-1:0] prod_p1 [ARRAY_COL];
   logic signed [PROD_W-1:0] r_p2    [ARRAY_COL];
   logic [ROW_W-1:0]         y_p3;

   logic [ROW_W:0]           fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]         wr_ptr, rd_ptr;
   logic [PTR_W:0]           fifo_count;
   logic [ROW_W:0]           head;
   logic                     push, pop;
   logic                     issue_ok, issue_is_last;

   assign push          = vld_p3;
   assign pop           = m_valid & m_ready;
   assign head          = fifo_mem[rd_ptr];
   assign m_valid       = (fifo_count != '0);
   assign m_data        = m_valid ? head[ROW_W-1:0] : '0;
   assign m_last        = m_valid & head[ROW_W];
   assign issue_is_last = ((issue_cnt + ONE_ROW) == rows_q);

   // Every issued read owns a FIFO slot until its beat leaves; a beat leaving this cycle frees one.
   assign issue_ok = (state == S_RUN) &&
                     ((int'(fifo_count) + $countones({acc_rd_en, vld_p0, vld_p1, vld_p2, vld_p3})
                       - int'(pop)) < FIFO_DEPTH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= S_IDLE;
         busy        <= 1'b0;
         done        <= 1'b0;
         acc_rd_en   <= 1'b0;
         acc_rd_addr <= '0;
         rd_last     <= 1'b0;
         issue_cnt   <= '0;
         rows_q      <= '0;
         vld_p0      <= 1'b0;
         vld_p1      <= 1'b0;
         vld_p2      <= 1'b0;
         vld_p3      <= 1'b0;
         last_p0     <= 1'b0;
         last_p1     <= 1'b0;
         last_p2     <= 1'b0;
         last_p3     <= 1'b0;
      end else begin
         vld_p0    <= acc_rd_en;
         last_p0   <= acc_rd_en & rd_last;
         vld_p1    <= vld_p0;
         last_p1   <= last_p0;
         vld_p2    <= vld_p1;
         last_p2   <= last_p1;
         vld_p3    <= vld_p2;
         last_p3   <= last_p2;
         acc_rd_en <= 1'b0;
         case (state)
            S_IDLE: begin
               if (start) begin
                  busy      <= 1'b1;
                  rows_q    <= cfg_rows;
                  issue_cnt <= '0;
                  state     <= (cfg_rows == '0) ? S_DONE : S_RUN;
               end
            end
            S_RUN: begin
               if (issue_ok) begin
                  acc_rd_en   <= 1'b1;
                  acc_rd_addr <= issue_cnt[ADDR_WIDTH-1:0];
                  rd_last     <= issue_is_last;
                  issue_cnt   <= issue_cnt + ONE_ROW;
                  if (issue_is_last)
                     state <= S_FLUSH;
               end
            end
            S_FLUSH: begin
               if (pop && m_last) begin
                  done  <= 1'b1;
                  state <= S_DONE;
               end
            end
            default: begin
               // Zero-row runs arrive with done still low and raise it one cycle later.
               if (done) begin
                  done  <= 1'b0;
                  busy  <= 1'b0;
                  state <= S_IDLE;
               end else begin
                  done <= 1'b1;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (state == S_IDLE && start) begin
         mult_q  <= cfg_mult;
         shift_q <= cfg_shift;
         zp_q    <= cfg_zero_point;
         relu_q  <= cfg_relu;
      end
   end

   // p0 -> p1: bias add and rescale multiply
   always_ff @(posedge clk) begin
      for (int l = 0; l < ARRAY_COL; l++) begin
         if (vld_p0)
            prod_p1[l] <= bias_scale(acc_rd_data[l*ACC_WIDTH +: ACC_WIDTH],
                                     bias_vec[l*ACC_WIDTH +: ACC_WIDTH], mult_q);
         // p1 -> p2: rounding right shift
         if (vld_p1)
            r_p2[l] <= round_shift(prod_p1[l], shift_q);
         // p2 -> p3: zero point, clamp, narrow
         if (vld_p2)
            y_p3[l*OUT_WIDTH +: OUT_WIDTH] <= zp_saturate(r_p2[l], zp_q, relu_q);
      end
   end

   // p3 -> output FIFO
   always_ff @(posedge clk) begin
      if (push)
         fifo_mem[wr_ptr] <= {last_p3, y_p3};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + PTR_ONE;
         if (pop)
            rd_ptr <= rd_ptr + PTR_ONE;
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CNT_ONE;
            2'b01:   fifo_count <= fifo_count - CNT_ONE;
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule
